// File: rtl/antirrebote_boton_if.sv
// ---------------------------------------------------------------------------
// antirrebote_boton_if
// Groups the button-side signals of the debouncer.
//   btn_in            raw asynchronous button pin (driven by the board/bench)
//   btn_estable       debounced level, 1 = pressed
//   pulso_presion     one-cycle pulse on an accepted press
//   pulso_liberacion  one-cycle pulse on an accepted release
//   pulso_largo       one-cycle pulse after a long hold, once per press
//   conteo_presiones  count of accepted presses, wraps 255 -> 0
// master: the side that owns the pin and consumes the conditioned outputs.
// slave : the debouncer itself.
// ---------------------------------------------------------------------------
interface antirrebote_boton_if;
  logic       btn_in;
  logic       btn_estable;
  logic       pulso_presion;
  logic       pulso_liberacion;
  logic       pulso_largo;
  logic [7:0] conteo_presiones;

  modport master (
    output btn_in,
    input  btn_estable,
    input  pulso_presion,
    input  pulso_liberacion,
    input  pulso_largo,
    input  conteo_presiones
  );

  modport slave (
    input  btn_in,
    output btn_estable,
    output pulso_presion,
    output pulso_liberacion,
    output pulso_largo,
    output conteo_presiones
  );
endinterface

// File: rtl/antirrebote_boton.sv
// ---------------------------------------------------------------------------
// antirrebote_boton
// Push-button conditioning: 2-FF synchroniser followed by a 4-state
// validation machine that accepts a level change only after it has been
// stable for DEBOUNCE_CYCLES cycles. Emits a clean level plus one-cycle
// press, release and long-press pulses and a wrapping press counter.
// Ports:
//   clk  system clock (50 MHz on the board)
//   rst  synchronous reset, active-high
//   bus  antirrebote_boton_if.slave (btn_in in, conditioned outputs out)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles to accept a change (>= 2)
//   LONG_CYCLES      cycles held pressed before pulso_largo (> DEBOUNCE_CYCLES)
//   ACTIVE_LOW       1 = pin reads 0 when pressed
// ---------------------------------------------------------------------------
module antirrebote_boton #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  antirrebote_boton_if.slave         bus
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int LARGO_W = $clog2(LONG_CYCLES);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [LARGO_W-1:0] LARGO_MAX = LARGO_W'(LONG_CYCLES - 1);
  localparam logic [LARGO_W-1:0] LARGO_ONE = LARGO_W'(1);

  typedef enum logic [1:0] {
    SUELTO,
    VALIDANDO_PRESION,
    PRESIONADO,
    VALIDANDO_LIBERACION
  } estado_t;

  // Synchroniser; reset loads the idle pin level so no phantom press appears.
  logic [1:0] r_sync;
  logic       w_btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {2{ACTIVE_LOW}};
    end else begin
      r_sync <= {r_sync[0], bus.btn_in};
    end
  end

  // Normalised "pressed" regardless of pin polarity.
  assign w_btn_s = r_sync[1] ^ ACTIVE_LOW;

  estado_t              r_state,         w_state_next;
  logic [CNT_W-1:0]     r_cnt,           w_cnt_next;
  logic [LARGO_W-1:0]   r_largo_cnt,     w_largo_cnt_next;
  logic                 r_largo_hecho,   w_largo_hecho_next;
  logic                 r_estable,       w_estable_next;
  logic                 r_presion,       w_presion_next;
  logic                 r_liberacion,    w_liberacion_next;
  logic                 r_largo,         w_largo_next;
  logic [7:0]           r_conteo,        w_conteo_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SUELTO;
      r_cnt         <= '0;
      r_largo_cnt   <= '0;
      r_largo_hecho <= 1'b0;
      r_estable     <= 1'b0;
      r_presion     <= 1'b0;
      r_liberacion  <= 1'b0;
      r_largo       <= 1'b0;
      r_conteo      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_largo_cnt   <= w_largo_cnt_next;
      r_largo_hecho <= w_largo_hecho_next;
      r_estable     <= w_estable_next;
      r_presion     <= w_presion_next;
      r_liberacion  <= w_liberacion_next;
      r_largo       <= w_largo_next;
      r_conteo      <= w_conteo_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_largo_cnt_next   = r_largo_cnt;
    w_largo_hecho_next = r_largo_hecho;
    w_estable_next     = r_estable;
    w_presion_next     = 1'b0;
    w_liberacion_next  = 1'b0;
    w_largo_next       = 1'b0;
    w_conteo_next      = r_conteo;

    unique case (r_state)
      SUELTO: begin
        if (w_btn_s) begin
          w_state_next = VALIDANDO_PRESION;
          w_cnt_next   = '0;
        end
      end

      VALIDANDO_PRESION: begin
        if (!w_btn_s) begin
          w_state_next = SUELTO;               // bounce: drop silently
        end else if (r_cnt == CNT_MAX) begin
          w_state_next       = PRESIONADO;
          w_estable_next     = 1'b1;
          w_presion_next     = 1'b1;
          w_conteo_next      = r_conteo + 8'd1;
          w_largo_cnt_next   = '0;
          w_largo_hecho_next = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      PRESIONADO: begin
        if (!w_btn_s) begin
          w_state_next = VALIDANDO_LIBERACION;
          w_cnt_next   = '0;
        end else begin
          if (r_largo_cnt != LARGO_MAX) begin
            w_largo_cnt_next = r_largo_cnt + LARGO_ONE;
          end
          // Saturated counter plus the done flag give one pulse per press.
          if (r_largo_cnt == LARGO_MAX && !r_largo_hecho) begin
            w_largo_next       = 1'b1;
            w_largo_hecho_next = 1'b1;
          end
        end
      end

      VALIDANDO_LIBERACION: begin
        if (w_btn_s) begin
          // Release glitch: resume the same press, long-press progress kept.
          w_state_next = PRESIONADO;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next      = SUELTO;
          w_estable_next    = 1'b0;
          w_liberacion_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_next = SUELTO;
      end
    endcase
  end

  assign bus.btn_estable      = r_estable;
  assign bus.pulso_presion    = r_presion;
  assign bus.pulso_liberacion = r_liberacion;
  assign bus.pulso_largo      = r_largo;
  assign bus.conteo_presiones = r_conteo;

endmodule

// File: tb/tb_antirrebote_boton.sv
// ---------------------------------------------------------------------------
// tb_antirrebote_boton
// Instance A: DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=0.
// Instance B: same timing, ACTIVE_LOW=1.
// Inputs change 1 time unit after a rising edge; outputs are read at that
// same point, so they show the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_antirrebote_boton;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  antirrebote_boton_if bus_a ();
  antirrebote_boton_if bus_b ();

  antirrebote_boton #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16),
    .ACTIVE_LOW      (1'b0)
  ) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  antirrebote_boton #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16),
    .ACTIVE_LOW      (1'b1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse counters sampled on the falling edge, plus a same-cycle overlap flag.
  int n_pres_a  = 0;
  int n_lib_a   = 0;
  int n_largo_a = 0;
  int n_pres_b  = 0;
  int n_overlap = 0;

  always @(negedge clk) begin
    if (bus_a.pulso_presion)    n_pres_a  <= n_pres_a + 1;
    if (bus_a.pulso_liberacion) n_lib_a   <= n_lib_a + 1;
    if (bus_a.pulso_largo)      n_largo_a <= n_largo_a + 1;
    if (bus_b.pulso_presion)    n_pres_b  <= n_pres_b + 1;
    if ((32'(bus_a.pulso_presion) + 32'(bus_a.pulso_liberacion) + 32'(bus_a.pulso_largo)) > 1)
      n_overlap <= n_overlap + 1;
  end

  typedef struct packed {
    logic       rst;
    logic       btn;
    logic       estable;
    logic       presion;
    logic       liberacion;
    logic       largo;
    logic [7:0] conteo;
  } vec_t;

  vec_t tbl [25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus_a.pulso_presion;
      1:       return bus_a.pulso_liberacion;
      2:       return bus_a.pulso_largo;
      default: return bus_b.pulso_presion;
    endcase
  endfunction

  // Ticks until the selected pulse is seen; it must appear after exactly
  // exp_ticks edges and be gone one edge later.
  task automatic wait_pulse(input int sel, input int exp_ticks, input string name);
    int  t;
    bit  seen;
    t    = 0;
    seen = 1'b0;
    while (!seen && t < exp_ticks + 20) begin
      tick();
      t++;
      if (sig(sel)) seen = 1'b1;
    end
    checks++;
    if (!seen || t != exp_ticks) begin
      failures++;
      $display("FAIL %s: pulse seen=%0d after %0d cycles, required after %0d", name, seen, t, exp_ticks);
    end else begin
      $display("ok   %s: pulse after %0d cycles", name, t);
    end
    if (seen) begin
      tick();
      check({name, "_one_cycle"}, 32'(sig(sel)), 32'd0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, p2;
    logic seen_high, seen_low;

    // rst, btn, estable, presion, liberacion, largo, conteo
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};  // edge k
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};  // k+2 validating
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};  // k+6 accepted
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};  // release edge r
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};  // r+6 released
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};  // 2-cycle blip
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

    rst_a        = 1'b1;
    bus_a.btn_in = 1'b0;
    rst_b        = 1'b1;
    bus_b.btn_in = 1'b1;   // active-low key released

    // ---------------- table: clean press, release, short blip ----------------
    for (int i = 0; i < 25; i++) begin
      logic [11:0] got;
      logic [11:0] exp;
      rst_a        = tbl[i].rst;
      bus_a.btn_in = tbl[i].btn;
      tick();
      got = {bus_a.btn_estable, bus_a.pulso_presion, bus_a.pulso_liberacion,
             bus_a.pulso_largo, bus_a.conteo_presiones};
      exp = {tbl[i].estable, tbl[i].presion, tbl[i].liberacion, tbl[i].largo, tbl[i].conteo};
      check($sformatf("vec%0d", i), 32'(got), 32'(exp));
    end

    // ---------------- reset clears counter, then quiet idle ----------------
    rst_a = 1'b1;
    bus_a.btn_in = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({bus_a.btn_estable, bus_a.pulso_presion, bus_a.pulso_liberacion,
                                bus_a.pulso_largo, bus_a.conteo_presiones}), 32'd0);
    rst_a = 1'b0;
    p0 = n_pres_a + n_lib_a + n_largo_a;
    repeat (50) tick();
    check("idle_no_pulses", 32'(n_pres_a + n_lib_a + n_largo_a - p0), 32'd0);

    // ---------------- bounce rejection ----------------
    p0 = n_pres_a;
    seen_high = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus_a.btn_in = (i % 4) != 3;
      tick();
      if (bus_a.btn_estable) seen_high = 1'b1;
    end
    check("bounce_no_press", 32'(n_pres_a - p0), 32'd0);
    check("bounce_estable_low", 32'(seen_high), 32'd0);
    bus_a.btn_in = 1'b1;
    repeat (12) tick();
    check("bounce_then_hold_press", 32'(n_pres_a - p0), 32'd1);
    check("bounce_then_hold_conteo", 32'(bus_a.conteo_presiones), 32'd1);
    bus_a.btn_in = 1'b0;
    repeat (12) tick();
    check("bounce_release_estable", 32'(bus_a.btn_estable), 32'd0);

    // ---------------- long press ----------------
    rst_a = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
    p0 = n_pres_a;
    p1 = n_lib_a;
    p2 = n_largo_a;
    bus_a.btn_in = 1'b1;
    wait_pulse(0, 7, "press_latency");
    wait_pulse(2, 15, "long_latency");   // 16 edges after the press pulse
    check("long_estable", 32'(bus_a.btn_estable), 32'd1);
    check("long_conteo", 32'(bus_a.conteo_presiones), 32'd1);
    repeat (23) tick();                  // 40 cycles held after acceptance
    check("long_once", 32'(n_largo_a - p2), 32'd1);
    check("long_single_press", 32'(n_pres_a - p0), 32'd1);
    check("long_no_release", 32'(n_lib_a - p1), 32'd0);
    bus_a.btn_in = 1'b0;
    wait_pulse(1, 7, "release_latency");
    check("release_estable", 32'(bus_a.btn_estable), 32'd0);

    // ---------------- counter wrap and release glitch ----------------
    rst_a = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
    p0 = n_pres_a;
    for (int i = 0; i < 256; i++) begin
      bus_a.btn_in = 1'b1;
      repeat (9) tick();
      bus_a.btn_in = 1'b0;
      repeat (9) tick();
    end
    check("wrap_presses", 32'(n_pres_a - p0), 32'd256);
    check("wrap_conteo", 32'(bus_a.conteo_presiones), 32'd0);
    bus_a.btn_in = 1'b1;
    wait_pulse(0, 7, "press257_latency");
    check("press257_conteo", 32'(bus_a.conteo_presiones), 32'd1);
    p1 = n_lib_a;
    seen_low = 1'b0;
    bus_a.btn_in = 1'b0;
    repeat (2) begin
      tick();
      if (!bus_a.btn_estable) seen_low = 1'b1;
    end
    bus_a.btn_in = 1'b1;
    repeat (20) begin
      tick();
      if (!bus_a.btn_estable) seen_low = 1'b1;
    end
    check("glitch_no_release", 32'(n_lib_a - p1), 32'd0);
    check("glitch_estable_held", 32'(seen_low), 32'd0);
    check("glitch_conteo", 32'(bus_a.conteo_presiones), 32'd1);
    bus_a.btn_in = 1'b0;
    repeat (10) tick();

    // ---------------- active-low instance ----------------
    check("b_reset_outputs", 32'({bus_b.btn_estable, bus_b.pulso_presion, bus_b.pulso_liberacion,
                                  bus_b.pulso_largo, bus_b.conteo_presiones}), 32'd0);
    rst_b = 1'b0;
    repeat (20) tick();
    check("b_no_false_press", 32'(n_pres_b), 32'd0);
    bus_b.btn_in = 1'b0;
    wait_pulse(3, 7, "b_press_latency");
    check("b_conteo", 32'(bus_b.conteo_presiones), 32'd1);
    check("b_estable", 32'(bus_b.btn_estable), 32'd1);
    bus_b.btn_in = 1'b1;
    repeat (10) tick();
    check("b_released", 32'(bus_b.btn_estable), 32'd0);
    bus_b.btn_in = 1'b0;
    repeat (4) tick();                   // now mid press validation
    rst_b = 1'b1;
    repeat (2) tick();
    check("b_midreset_conteo", 32'(bus_b.conteo_presiones), 32'd0);
    check("b_midreset_estable", 32'(bus_b.btn_estable), 32'd0);
    rst_b = 1'b0;
    wait_pulse(3, 7, "b_press_after_reset");
    check("b_after_reset_conteo", 32'(bus_b.conteo_presiones), 32'd1);

    tick();
    check("pulse_overlap", 32'(n_overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
